// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The loader packs a byte stream into 19-bit instruction words.
package imem_loader_pkg;

   localparam int unsigned ADDR_W         = 12;
   localparam int unsigned INSTR_W        = 19;
   localparam int unsigned BYTES_PER_WORD = 3;
   localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

   // Bits of the third byte that have no room in the 19-bit word.
   localparam logic [7:0] BYTE2_MASK = 8'b1111_1000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_B0,
      ST_B1,
      ST_B2,
      ST_WRITE,
      ST_DONE
   } state_e;

   typedef logic [LANE_W-1:0] lane_t;

   function automatic lane_t lane_of(input state_e s);
      case (s)
         ST_B1:   return lane_t'(1);
         ST_B2:   return lane_t'(2);
         default: return lane_t'(0);
      endcase
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Control, byte-stream and memory-write signals of the loader.
// The slave modport is the loader itself; master is its environment.
interface imem_loader_if;
   import imem_loader_pkg::*;

   logic               start;
   logic [ADDR_W-1:0]  load_len;
   logic               byte_valid;
   logic [7:0]         byte_data;
   logic               byte_ready;
   logic               wr_en;
   logic [ADDR_W-1:0]  wr_addr;
   logic [INSTR_W-1:0] wr_data;
   logic               cpu_rst;
   logic               busy;
   logic               done;
   logic               err;

   modport slave (
      input  start, load_len, byte_valid, byte_data,
      output byte_ready, wr_en, wr_addr, wr_data, cpu_rst, busy, done, err
   );

   modport master (
      output start, load_len, byte_valid, byte_data,
      input  byte_ready, wr_en, wr_addr, wr_data, cpu_rst, busy, done, err
   );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packing register: places each accepted byte into its lane of the word
// and flags a third byte whose upper bits would be dropped.
module word_assembler
   import imem_loader_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  lane_t              lane_i,
   input  logic               load_i,
   input  logic [7:0]         byte_i,
   output logic [INSTR_W-1:0] word_o,
   output logic               frm_err_o
);

   logic [INSTR_W-1:0] word_q, word_d;

   always_comb begin
      word_d = word_q;
      if (load_i) begin
         case (lane_i)
            lane_t'(0): word_d[7:0]   = byte_i;
            lane_t'(1): word_d[15:8]  = byte_i;
            default:    word_d[18:16] = byte_i[2:0];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) word_q <= '0;
      else      word_q <= word_d;
   end

   assign word_o    = word_q;
   assign frm_err_o = load_i && (lane_i == lane_t'(2)) && |(byte_i & BYTE2_MASK);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams bytes into 19-bit words written to
// sequential addresses, holding the datapath in reset until the load ends.
module imem_loader
   import imem_loader_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   imem_loader_if.slave   bus
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] addr_inc;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              cpu_rst_q, cpu_rst_d;

   logic               in_byte_state;
   logic               xfer;
   logic               frm_err;
   logic [INSTR_W-1:0] word;

   assign in_byte_state = (state_q == ST_B0) || (state_q == ST_B1) || (state_q == ST_B2);
   assign bus.byte_ready = rst && in_byte_state;
   assign xfer           = bus.byte_valid && bus.byte_ready;
   assign addr_inc       = addr_q + 1'b1;

   word_assembler u_asm (
      .clk       (clk),
      .rst       (rst),
      .lane_i    (lane_of(state_q)),
      .load_i    (xfer),
      .byte_i    (bus.byte_data),
      .word_o    (word),
      .frm_err_o (frm_err)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      err_d     = err_q;
      cpu_rst_d = cpu_rst_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               len_d     = bus.load_len;
               err_d     = 1'b0;
               addr_d    = '0;
               cpu_rst_d = 1'b1;
               state_d   = (bus.load_len == '0) ? ST_DONE : ST_B0;
            end
         end
         ST_B0: if (xfer) state_d = ST_B1;
         ST_B1: if (xfer) state_d = ST_B2;
         ST_B2: begin
            if (xfer) begin
               state_d = ST_WRITE;
               if (frm_err) err_d = 1'b1;
            end
         end
         ST_WRITE: begin
            addr_d  = addr_inc;
            state_d = (addr_inc == len_q) ? ST_DONE : ST_B0;
         end
         ST_DONE: begin
            cpu_rst_d = 1'b0;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // done/busy are registered from the next state so they align with it.
      done_d = (state_d == ST_DONE);
      busy_d = (state_d == ST_B0) || (state_d == ST_B1) ||
               (state_d == ST_B2) || (state_d == ST_WRITE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         cpu_rst_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         err_q     <= err_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         cpu_rst_q <= cpu_rst_d;
      end
   end

   assign bus.wr_en   = rst && (state_q == ST_WRITE);
   assign bus.wr_addr = addr_q;
   assign bus.wr_data = word;
   assign bus.cpu_rst = cpu_rst_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: loads, backpressure, framing error,
// zero length, ignored start and reset in the middle of a load.
module tb_imem_loader;
   import imem_loader_pkg::*;

   logic clk;
   logic rst;
   imem_loader_if bus ();

   imem_loader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned passed;
   int unsigned total;
   int unsigned done_cnt;
   logic [ADDR_W-1:0]  wa_q[$];
   logic [INSTR_W-1:0] wd_q[$];
   logic [7:0]         bp [3];

   always @(negedge clk) begin
      if (bus.wr_en) begin
         wa_q.push_back(bus.wr_addr);
         wd_q.push_back(bus.wr_data);
      end
      if (bus.done) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
      done_cnt = 0;
   endtask

   // Leaves byte_valid high so consecutive calls stream back-to-back.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      while (!bus.byte_ready && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) chk("byte_ready_timeout", 32'(bus.byte_ready), 32'd1);
      tick();
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!bus.done && n < 20) begin
         tick();
         n++;
      end
      chk("done_seen", 32'(bus.done), 32'd1);
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] len);
      bus.start    = 1'b1;
      bus.load_len = len;
      tick();
      bus.start    = 1'b0;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      done_cnt = 0;
      bp[0] = 8'h01; bp[1] = 8'h02; bp[2] = 8'h03;
      rst            = 1'b0;
      bus.start      = 1'b1;
      bus.load_len   = 12'd5;
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h00;

      // Reset held with start and byte_valid active
      tick();
      tick();
      chk("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
      chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
      bus.start      = 1'b0;
      bus.byte_valid = 1'b0;
      rst            = 1'b1;
      tick();
      chk("idle_busy", 32'(bus.busy), 32'd0);
      clear_log();

      // Two-word load, back-to-back bytes; start during DONE is ignored
      do_start(12'd2);
      chk("ld2_busy", 32'(bus.busy), 32'd1);
      chk("ld2_ready", 32'(bus.byte_ready), 32'd1);
      send_byte(8'h34); send_byte(8'h12); send_byte(8'h05);
      send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h07);
      bus.byte_valid = 1'b0;
      tick();
      chk("ld2_done", 32'(bus.done), 32'd1);
      chk("ld2_done_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      chk("ld2_done_busy", 32'(bus.busy), 32'd0);
      bus.start    = 1'b1;
      bus.load_len = 12'd3;
      tick();
      bus.start = 1'b0;
      chk("ld2_after_done", 32'(bus.done), 32'd0);
      chk("ld2_cpu_rst_fall", 32'(bus.cpu_rst), 32'd0);
      chk("done_start_ignored_busy", 32'(bus.busy), 32'd0);
      chk("done_start_ignored_ready", 32'(bus.byte_ready), 32'd0);
      chk("ld2_err", 32'(bus.err), 32'd0);
      chk("ld2_nwr", 32'(wa_q.size()), 32'd2);
      if (wa_q.size() == 2) begin
         chk("ld2_a0", 32'(wa_q[0]), 32'd0);
         chk("ld2_d0", 32'(wd_q[0]), 32'h51234);
         chk("ld2_a1", 32'(wa_q[1]), 32'd1);
         chk("ld2_d1", 32'(wd_q[1]), 32'h7FFFF);
      end
      chk("ld2_done_cnt", done_cnt, 32'd1);
      clear_log();

      // Backpressure: byte_valid alternates every cycle
      do_start(12'd1);
      begin
         int idx;
         logic acc;
         idx = 0;
         for (int cyc = 0; cyc < 40 && idx < 3; cyc++) begin
            bus.byte_valid = (cyc % 2 == 0);
            bus.byte_data  = bp[idx];
            acc = bus.byte_valid && bus.byte_ready;
            tick();
            if (acc) idx++;
         end
         chk("bp_bytes_sent", 32'(idx), 32'd3);
      end
      bus.byte_valid = 1'b0;
      wait_done();
      tick();
      chk("bp_nwr", 32'(wa_q.size()), 32'd1);
      if (wa_q.size() == 1) begin
         chk("bp_a0", 32'(wa_q[0]), 32'd0);
         chk("bp_d0", 32'(wd_q[0]), 32'h30201);
      end
      clear_log();

      // Framing error on byte 2
      do_start(12'd1);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h09);
      bus.byte_valid = 1'b0;
      chk("fe_err_set", 32'(bus.err), 32'd1);
      wait_done();
      tick();
      chk("fe_err_idle", 32'(bus.err), 32'd1);
      chk("fe_cpu_rst", 32'(bus.cpu_rst), 32'd0);
      chk("fe_nwr", 32'(wa_q.size()), 32'd1);
      if (wd_q.size() == 1) chk("fe_d0", 32'(wd_q[0]), 32'h10201);
      clear_log();

      // Zero-length load also clears err
      do_start(12'd0);
      chk("z_err_clr", 32'(bus.err), 32'd0);
      chk("z_done", 32'(bus.done), 32'd1);
      chk("z_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      chk("z_busy", 32'(bus.busy), 32'd0);
      tick();
      chk("z_done_fall", 32'(bus.done), 32'd0);
      chk("z_cpu_rst_fall", 32'(bus.cpu_rst), 32'd0);
      chk("z_nwr", 32'(wa_q.size()), 32'd0);
      chk("z_done_cnt", done_cnt, 32'd1);
      clear_log();

      // start while in B1 has no effect
      do_start(12'd1);
      send_byte(8'hAA);
      bus.byte_valid = 1'b0;
      do_start(12'd7);
      chk("b1_start_busy", 32'(bus.busy), 32'd1);
      chk("b1_start_ready", 32'(bus.byte_ready), 32'd1);
      send_byte(8'hBB); send_byte(8'h02);
      bus.byte_valid = 1'b0;
      wait_done();
      tick();
      chk("b1_nwr", 32'(wa_q.size()), 32'd1);
      if (wd_q.size() == 1) chk("b1_d0", 32'(wd_q[0]), 32'h2BBAA);
      clear_log();

      // Reset during B2 of word 2 (third word) in a 5-word load
      do_start(12'd5);
      send_byte(8'h10); send_byte(8'h20); send_byte(8'h01);
      send_byte(8'h30); send_byte(8'h40); send_byte(8'h02);
      send_byte(8'h21); send_byte(8'h43);
      bus.byte_valid = 1'b0;
      chk("mr_busy_b2", 32'(bus.busy), 32'd1);
      rst = 1'b0;
      tick();
      chk("mr_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      chk("mr_busy", 32'(bus.busy), 32'd0);
      chk("mr_ready", 32'(bus.byte_ready), 32'd0);
      chk("mr_wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("mr_wr_data", 32'(bus.wr_data), 32'd0);
      chk("mr_nwr", 32'(wa_q.size()), 32'd2);
      if (wa_q.size() == 2) begin
         chk("mr_a0", 32'(wa_q[0]), 32'd0);
         chk("mr_d0", 32'(wd_q[0]), 32'h12010);
         chk("mr_a1", 32'(wa_q[1]), 32'd1);
         chk("mr_d1", 32'(wd_q[1]), 32'h24030);
      end
      rst = 1'b1;
      tick();
      clear_log();
      do_start(12'd1);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h03);
      bus.byte_valid = 1'b0;
      wait_done();
      tick();
      chk("fresh_nwr", 32'(wa_q.size()), 32'd1);
      if (wa_q.size() == 1) begin
         chk("fresh_a0", 32'(wa_q[0]), 32'd0);
         chk("fresh_d0", 32'(wd_q[0]), 32'h32211);
      end
      chk("fresh_cpu_rst", 32'(bus.cpu_rst), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
